// File: rtl/search_pkg.sv
// search_pkg
// Shared types, constants and helpers for the brute-force search controller.
//   state_e    : controller states (IDLE, RUN, DRAIN, FOUND, DONE)
//   BASE_W     : base width for the default configuration (candidate minus lane bits)
//   N_LANES    : lane count for the default configuration
//   lowest_set : priority encoder returning the index of the lowest set flag
// The priority encoder handles up to MAX_LANES flags; narrower vectors are
// zero-extended by the caller, which limits LANE_BITS to MAX_LANE_BITS.
package search_pkg;

    localparam int DEF_CAND_W    = 32;
    localparam int DEF_LANE_BITS = 3;
    localparam int BASE_W        = DEF_CAND_W - DEF_LANE_BITS;
    localparam int N_LANES       = 2 ** DEF_LANE_BITS;

    localparam int MAX_LANE_BITS = 6;
    localparam int MAX_LANES     = 2 ** MAX_LANE_BITS;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FOUND,
        DONE
    } state_e;

    // Scanning from the top down means the last hit written is the lowest
    // index, so the lowest lane wins when several lanes match at once.
    function automatic logic [MAX_LANE_BITS-1:0] lowest_set(input logic [MAX_LANES-1:0] flags);
        logic [MAX_LANE_BITS-1:0] idx;
        idx = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (flags[i]) begin
                idx = MAX_LANE_BITS'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/search_controller_if.sv
// search_controller_if
// Bundles the control inputs, lane match flags and result outputs of the
// search controller.
//   clear, enable, step : board-side controls (step is a debounced pulse)
//   lane_found          : per-lane match flags from the pipeline array
//   base_out/base_valid : base presented to the lanes and its issue strobe
//   running/done/found  : status
//   found_candidate/found_lane : latched match result
// Modports: master = board/pipeline side, slave = controller.
interface search_controller_if #(
    parameter int CAND_W    = 32,
    parameter int LANE_BITS = 3
);
    import search_pkg::*;

    localparam int IF_BASE_W  = CAND_W - LANE_BITS;
    localparam int IF_N_LANES = 2 ** LANE_BITS;

    logic                  clear;
    logic                  enable;
    logic                  step;
    logic [IF_N_LANES-1:0] lane_found;
    logic [IF_BASE_W-1:0]  base_out;
    logic                  base_valid;
    logic                  running;
    logic                  done;
    logic                  found;
    logic [CAND_W-1:0]     found_candidate;
    logic [LANE_BITS-1:0]  found_lane;

    modport master (
        output clear, enable, step, lane_found,
        input  base_out, base_valid, running, done, found, found_candidate, found_lane
    );

    modport slave (
        input  clear, enable, step, lane_found,
        output base_out, base_valid, running, done, found, found_candidate, found_lane
    );

endinterface

// File: rtl/result_delay_line.sv
// result_delay_line
// Fixed-depth shift register that replays each issue slot after DEPTH cycles,
// so the controller knows which base a lane result belongs to.
//   clk, rst_n : clock and asynchronous active-low reset
//   flush      : synchronous clear of every stage
//   slot       : value entering the line this cycle
//   tap        : value that entered DEPTH cycles ago
module result_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] slot,
    output logic [WIDTH-1:0] tap
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shifts one stage per cycle, with or without a real issue, so bubbles
    // stay aligned with the pipelines. A flush empties every stage so that
    // nothing issued before a restart can later look like a match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= slot;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tap = stages[DEPTH-1];

endmodule

// File: rtl/search_controller.sv
// search_controller
// Drives a base candidate to 2**LANE_BITS MD5 lanes (lane i hashes
// {base, i}). Supports free-run, pause and single-step. After the last base
// it drains the pipelines before reporting done. A latency-matched delay line
// lets it latch the exact candidate that matched.
//   CLK, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : controls, lane match flags, issued base and results
module search_controller #(
    parameter int CAND_W       = 32,
    parameter int LANE_BITS    = 3,
    parameter int PIPE_LATENCY = 64
) (
    input  logic                CLK,
    input  logic                reset_n,
    search_controller_if.slave  bus
);
    import search_pkg::*;

    localparam int CTRL_BASE_W = CAND_W - LANE_BITS;
    localparam int DRAIN_W     = $clog2(PIPE_LATENCY + 1);
    localparam int TAP_W       = CTRL_BASE_W + 1;

    state_e                 state;
    state_e                 next_state;
    logic [CTRL_BASE_W-1:0] base_cnt;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic [CAND_W-1:0]      cand_q;
    logic [LANE_BITS-1:0]   lane_q;
    logic                   issue;
    logic                   match;
    logic                   last_base;
    logic                   drain_expired;
    logic [TAP_W-1:0]       tap;
    logic                   tap_valid;
    logic [CTRL_BASE_W-1:0] tap_base;
    logic [LANE_BITS-1:0]   hit_lane;

    result_delay_line #(
        .WIDTH (TAP_W),
        .DEPTH (PIPE_LATENCY)
    ) u_delay (
        .clk   (CLK),
        .rst_n (reset_n),
        .flush (bus.clear),
        .slot  ({issue, base_cnt}),
        .tap   (tap)
    );

    assign {tap_valid, tap_base} = tap;
    assign hit_lane = LANE_BITS'(lowest_set(MAX_LANES'(bus.lane_found)));

    // State register.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and issue decision. The all-ones base is the final issue,
    // so its cycle sends the FSM to DRAIN. Two overrides apply in order:
    // a match aligned with a valid tap beats a terminal issue or drain
    // expiry, and clear beats everything and cancels any issue.
    always_comb begin
        next_state    = state;
        issue         = 1'b0;
        last_base     = &base_cnt;
        drain_expired = (drain_cnt == DRAIN_W'(PIPE_LATENCY - 1));
        match         = tap_valid && (|bus.lane_found) &&
                        (state == IDLE || state == RUN || state == DRAIN);

        case (state)
            IDLE: begin
                if (bus.enable) begin
                    next_state = RUN;
                end else if (bus.step) begin
                    issue = 1'b1;
                    if (last_base) begin
                        next_state = DRAIN;
                    end
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    next_state = IDLE;
                end else begin
                    issue = 1'b1;
                    if (last_base) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_expired) begin
                    next_state = DONE;
                end
            end
            FOUND:   next_state = FOUND;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase

        if (match) begin
            next_state = FOUND;
        end

        if (bus.clear) begin
            next_state = IDLE;
            issue      = 1'b0;
        end
    end

    // Base counter, drain counter and latched result. The counter simply
    // wraps after the final base; the FSM is in DRAIN by then, so the
    // wrapped value is never issued. The drain counter only runs inside
    // DRAIN, so it starts from zero on entry.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            base_cnt  <= '0;
            drain_cnt <= '0;
            cand_q    <= '0;
            lane_q    <= '0;
        end else if (bus.clear) begin
            base_cnt  <= '0;
            drain_cnt <= '0;
            cand_q    <= '0;
            lane_q    <= '0;
        end else begin
            if (issue) begin
                base_cnt <= base_cnt + 1'b1;
            end
            if (state != DRAIN) begin
                drain_cnt <= '0;
            end else if (!drain_expired) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
            if (match) begin
                lane_q <= hit_lane;
                cand_q <= {tap_base, hit_lane};
            end
        end
    end

    assign bus.base_out        = base_cnt;
    assign bus.base_valid      = issue;
    assign bus.running         = (state == RUN) || (state == DRAIN);
    assign bus.done            = (state == DONE);
    assign bus.found           = (state == FOUND);
    assign bus.found_candidate = cand_q;
    assign bus.found_lane      = lane_q;

endmodule
